// File: rtl/idma_desc64_mc_pkg.sv
// Shared types and constants for the multi-channel desc64 AR generator.
// Helper functions size the in-flight counters and the fixed AR burst shape.
package idma_desc64_mc_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic        user;
    } ar_chan_t;

    localparam logic [1:0] BurstIncr = 2'b01;

    function automatic int unsigned cnt_width(input int unsigned n_spec);
        return $clog2(n_spec + 1);
    endfunction

    function automatic int unsigned axi_len(input int unsigned desc_bits,
                                            input int unsigned data_width);
        return desc_bits / data_width - 1;
    endfunction

    function automatic int unsigned axi_size(input int unsigned data_width);
        int unsigned s;
        s = $clog2(data_width / 8);
        return (s > 7) ? 7 : s;
    endfunction

endpackage

// File: rtl/idma_desc64_ar_chan_ctrl.sv
// One descriptor chain: tracks the oldest unresolved descriptor, the number of
// speculative ARs in flight, and reports wrong-path ARs on resolve.
module idma_desc64_ar_chan_ctrl
    import idma_desc64_mc_pkg::*;
#(
    parameter int unsigned NSpeculation = 4,
    parameter int unsigned DescBytes    = 32,
    parameter type         addr_t       = logic [63:0],
    parameter type         usage_t      = logic [3:0],
    parameter type         cnt_t        = logic [2:0]
) (
    input  logic   clk,
    input  logic   rst_n,
    input  addr_t  queued_addr,
    input  logic   queued_addr_valid,
    output logic   queued_addr_ready,
    input  addr_t  next_addr,
    input  logic   next_addr_valid,
    input  usage_t avail_slots,
    output logic   req,
    input  logic   gnt,
    output addr_t  ar_addr,
    output cnt_t   flush_cnt,
    output logic   flush_valid,
    output logic   busy
);

    localparam int unsigned DescShift = $clog2(DescBytes);
    localparam int unsigned CmpW      = ($bits(usage_t) > $bits(cnt_t)) ? $bits(usage_t) : $bits(cnt_t);
    localparam cnt_t        MaxInfl   = cnt_t'(NSpeculation);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StActive = 1'b1;

    logic [0:0] state_reg, state_next;
    addr_t      base_reg, base_next;
    cnt_t       infl_reg, infl_next;

    addr_t           exp_addr;
    logic            is_end;
    logic            is_commit;
    logic [CmpW-1:0] slots_ext;
    logic [CmpW-1:0] infl_ext;

    assign exp_addr  = base_reg + addr_t'(DescBytes);
    assign is_end    = (next_addr == '1);
    assign is_commit = !is_end && (next_addr == exp_addr);
    assign slots_ext = CmpW'(avail_slots);
    assign infl_ext  = CmpW'(infl_reg);

    assign ar_addr = base_reg + (addr_t'(infl_reg) << DescShift);
    assign req     = (state_reg == StActive) && (infl_reg < MaxInfl)
                   && (slots_ext > infl_ext) && !next_addr_valid;
    assign busy    = (state_reg == StActive) || (infl_reg != '0);

    always_comb begin
        state_next        = state_reg;
        base_next         = base_reg;
        infl_next         = gnt ? infl_reg + cnt_t'(1) : infl_reg;
        queued_addr_ready = 1'b0;
        flush_valid       = 1'b0;
        flush_cnt         = '0;
        case (state_reg)
            StIdle: begin
                queued_addr_ready = 1'b1;
                if (queued_addr_valid) begin
                    base_next  = queued_addr;
                    state_next = StActive;
                end
            end
            default: begin
                if (next_addr_valid) begin
                    if (is_commit) begin
                        base_next = exp_addr;
                        if (infl_reg != '0) begin
                            infl_next = infl_reg - cnt_t'(1) + cnt_t'(gnt);
                        end
                    end else begin
                        // The resolved descriptor itself was useful; everything behind it is wrong-path.
                        flush_valid = 1'b1;
                        flush_cnt   = (infl_reg == '0) ? '0 : infl_reg - cnt_t'(1);
                        infl_next   = '0;
                        if (is_end) begin
                            queued_addr_ready = 1'b1;
                            if (queued_addr_valid) begin
                                base_next = queued_addr;
                            end else begin
                                state_next = StIdle;
                            end
                        end else begin
                            base_next = next_addr;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= StIdle;
            base_reg  <= '0;
            infl_reg  <= '0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            infl_reg  <= infl_next;
        end
    end

endmodule

// File: rtl/idma_desc64_ar_gen_mc.sv
// Multi-channel descriptor AR generator: per-channel speculative prefetch
// controllers share one registered AXI AR port through a round-robin arbiter.
module idma_desc64_ar_gen_mc
    import idma_desc64_mc_pkg::*;
#(
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned NChannels     = 2,
    parameter int unsigned NSpeculation  = 4,
    parameter type         descriptor_t  = logic [255:0],
    parameter type         axi_ar_chan_t = ar_chan_t,
    parameter type         axi_id_t      = logic [3:0],
    parameter type         addr_t        = logic [63:0],
    parameter type         usage_t       = logic [3:0],
    parameter type         cnt_t         = logic [cnt_width(NSpeculation)-1:0]
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    output axi_ar_chan_t                 axi_ar_chan_o,
    output logic                         axi_ar_chan_valid_o,
    input  logic                         axi_ar_chan_ready_i,
    input  axi_id_t                      axi_ar_id_base_i,
    input  addr_t  [NChannels-1:0]       queued_addr_i,
    input  logic   [NChannels-1:0]       queued_addr_valid_i,
    output logic   [NChannels-1:0]       queued_addr_ready_o,
    input  addr_t  [NChannels-1:0]       next_addr_i,
    input  logic   [NChannels-1:0]       next_addr_valid_i,
    input  usage_t [NChannels-1:0]       avail_slots_i,
    output cnt_t   [NChannels-1:0]       flush_cnt_o,
    output logic   [NChannels-1:0]       flush_valid_o,
    output logic   [NChannels-1:0]       busy_o
);

    localparam int unsigned DescBytes = $bits(descriptor_t) / 8;
    localparam logic [7:0]  AxiLen    = 8'(axi_len($bits(descriptor_t), DataWidth));
    localparam logic [2:0]  AxiSize   = 3'(axi_size(DataWidth));
    localparam int unsigned IdxW      = (NChannels > 1) ? $clog2(NChannels) : 1;

    logic  [NChannels-1:0] req;
    logic  [NChannels-1:0] gnt;
    addr_t [NChannels-1:0] ch_addr;

    for (genvar gi = 0; gi < NChannels; gi++) begin : g_chan
        idma_desc64_ar_chan_ctrl #(
            .NSpeculation(NSpeculation),
            .DescBytes   (DescBytes),
            .addr_t      (addr_t),
            .usage_t     (usage_t),
            .cnt_t       (cnt_t)
        ) i_chan (
            .clk              (clk_i),
            .rst_n            (rst_ni),
            .queued_addr      (queued_addr_i[gi]),
            .queued_addr_valid(queued_addr_valid_i[gi]),
            .queued_addr_ready(queued_addr_ready_o[gi]),
            .next_addr        (next_addr_i[gi]),
            .next_addr_valid  (next_addr_valid_i[gi]),
            .avail_slots      (avail_slots_i[gi]),
            .req              (req[gi]),
            .gnt              (gnt[gi]),
            .ar_addr          (ch_addr[gi]),
            .flush_cnt        (flush_cnt_o[gi]),
            .flush_valid      (flush_valid_o[gi]),
            .busy             (busy_o[gi])
        );
    end

    axi_ar_chan_t    ar_reg, ar_next;
    logic            ar_valid_reg;
    logic [IdxW-1:0] rr_reg;
    logic [IdxW-1:0] sel_idx;
    logic            sel_valid;
    logic            take;
    int unsigned     cand;

    // The output register only accepts a new AR when empty or draining this cycle.
    assign take = !ar_valid_reg || axi_ar_chan_ready_i;

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NChannels; k++) begin
            cand = (32'(rr_reg) + k) % NChannels;
            if (!sel_valid && req[cand[IdxW-1:0]]) begin
                sel_valid = 1'b1;
                sel_idx   = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (take && sel_valid) begin
            gnt[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        ar_next       = '0;
        ar_next.id    = axi_ar_id_base_i + axi_id_t'(sel_idx);
        ar_next.addr  = ch_addr[sel_idx];
        ar_next.len   = AxiLen;
        ar_next.size  = AxiSize;
        ar_next.burst = BurstIncr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_reg       <= '0;
            ar_valid_reg <= 1'b0;
            rr_reg       <= '0;
        end else if (take) begin
            ar_valid_reg <= sel_valid;
            if (sel_valid) begin
                ar_reg <= ar_next;
                rr_reg <= (sel_idx == IdxW'(NChannels - 1)) ? '0 : sel_idx + 1'b1;
            end
        end
    end

    assign axi_ar_chan_o       = ar_reg;
    assign axi_ar_chan_valid_o = ar_valid_reg;

endmodule
